// File: rtl/posit_decode_pipe.sv
// Two-stage posit field extractor: S1 registers sign, special flags and magnitude,
// S2 registers regime count, exponent, scale and hidden-bit-normalised mantissa.
module posit_decode_pipe #(
    parameter int unsigned N  = 32,
    parameter int unsigned ES = 2,
    parameter int unsigned RS = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            IN,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    Sign,
    output logic [RS:0]             R_O,
    output logic signed [RS+ES:0]   LE_O,
    output logic [ES-1:0]           E_O,
    output logic [N-1:0]            Mant,
    output logic                    zero,
    output logic                    inf,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned RW = RS + 1;
    localparam int unsigned LW = RS + ES + 1;
    localparam int unsigned FW = N - 1 - ES;
    localparam logic signed [LW-1:0] One = 1;

    logic         s1_valid;
    logic         s1_sign;
    logic         s1_zero;
    logic         s1_inf;
    logic [N-1:0] s1_a;

    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_inf   <= 1'b0;
            s1_a     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= IN[N-1];
                s1_zero <= (IN == '0);
                s1_inf  <= (IN == {1'b1, {(N-1){1'b0}}});
                s1_a    <= IN[N-1] ? -IN : IN;
            end
        end
    end

    logic                 r;
    logic [N-2:0]         x;
    logic [RW-1:0]        m;
    logic [N-2:0]         shifted;
    logic [ES-1:0]        e;
    logic signed [LW-1:0] m_s;
    logic signed [LW-1:0] k;
    logic signed [LW-1:0] le;

    always_comb begin
        r = s1_a[N-2];
        // Bits differing from the regime bit are 1; the highest one is the terminator.
        x = s1_a[N-2:0] ^ {(N-1){r}};
        m = RW'(N - 1);
        for (int i = 0; i < int'(N) - 1; i++) begin
            if (x[i]) begin
                m = RW'(N - 2 - i);
            end
        end
        // Shift out the regime run plus terminator; a full run shifts everything out.
        shifted = s1_a[N-2:0] << (m + RW'(1));
        e       = shifted[N-2 -: ES];
        m_s     = {{(LW-RW){1'b0}}, m};
        k       = r ? (m_s - One) : (-m_s);
        le      = (k <<< ES) + {{(LW-ES){1'b0}}, e};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Sign      <= 1'b0;
            R_O       <= '0;
            LE_O      <= '0;
            E_O       <= '0;
            Mant      <= '0;
            zero      <= 1'b0;
            inf       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                Sign <= s1_sign;
                zero <= s1_zero;
                inf  <= s1_inf;
                if (s1_zero || s1_inf) begin
                    R_O  <= '0;
                    LE_O <= '0;
                    E_O  <= '0;
                    Mant <= '0;
                end else begin
                    R_O  <= m;
                    LE_O <= le;
                    E_O  <= e;
                    Mant <= {1'b1, shifted[FW-1:0], {ES{1'b0}}};
                end
            end
        end
    end

endmodule

// File: doc/posit_decode_pipe.md
Name: posit_decode_pipe

Overview:
- Pipelined posit field extractor: the decode direction of the posit packing/rounding stage.
- Accepts one N-bit posit word per transaction.
- Returns sign, regime run length, signed scale, exponent field, hidden-bit-normalised mantissa, and zero/NaR flags.
- Sits at the front of the posit arithmetic datapath (adder/multiplier operand decode); valid/ready on both sides.

Parameters:
- N, 32, posit word width (>= ES+3)
- ES, 2, exponent field width (>= 1)
- RS, $clog2(N), regime-count width base; R_O is RS+1 bits, LE_O is RS+ES+1 bits signed

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- IN  in  N  posit word
- in_valid  in  1  IN valid
- in_ready  out  1  block can accept IN this cycle
- Sign  out  1  posit sign bit
- R_O  out  RS+1  regime run length m (identical bits after sign, terminator excluded)
- LE_O  out  RS+ES+1 signed  scale = k*2^ES + E_O
- E_O  out  ES  exponent field, zero-padded if truncated
- Mant  out  N  {1'b1, fraction left-aligned, zero-filled}
- zero  out  1  IN == 0
- inf  out  1  IN == {1'b1, {N-1{0}}} (NaR)
- out_valid  out  1  outputs valid
- out_ready  in  1  consumer accepts outputs

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset: all outputs and internal valid bits clear to 0 immediately on rst_n low, including mid-transaction. In-flight words are discarded. in_ready = 1 after reset deassertion.
- Transfers: an input transfer is in_valid & in_ready; an output transfer is out_valid & out_ready.
- Pipeline: two register stages.
  - S1 captures IN, Sign = IN[N-1], zero/inf flags, and magnitude A = Sign ? -IN : IN.
  - S2 performs regime count and field shift; its registers drive all outputs.
- Latency: exactly 2 cycles from input transfer to out_valid, with no stall. Throughput 1 word/cycle.
- Flow control:
  - s2 advances when !s2_valid | out_ready.
  - s1 advances when !s1_valid | s2 advances.
  - in_ready = s1 advance condition, combinational from out_ready; this path is permitted.
  - A stalled stage holds its data and valid unchanged. No word is dropped or duplicated.
  - Simultaneous output and input transfer in the same cycle with a full pipe is legal and sustains full rate.
- Decode, applied to A[N-2:0]:
  - r = A[N-2]. m = count of consecutive bits equal to r from bit N-2 downward, range 1..N-1.
  - k = r ? m-1 : -m.
  - The terminator bit is skipped if present (m < N-1).
  - The next ES bits form E_O, MSB first. Missing low bits are 0.
  - Remaining bits form the fraction, left-aligned under the hidden 1 in Mant[N-1]. Low bits are 0-filled.
  - LE_O = (k <<< ES) + E_O, computed in full signed width; no saturation needed, since it fits by construction.
- Specials:
  - zero: Sign = 0, R_O = 0, LE_O = 0, E_O = 0, Mant = 0, inf = 0.
  - NaR: Sign = 1, inf = 1, all other fields 0.
  - zero and inf are never both 1.
- out_valid deasserted: output fields hold their last values; the bench must not check them.

Test Plan:
- 1.0 and 2.0 (N=32, ES=2): IN=0x40000000 -> after 2 cycles Sign=0, R_O=1, LE_O=0, E_O=0, Mant=0x80000000. Then IN=0x48000000 -> E_O=1, LE_O=1.
- Fraction and sign: IN=0x44000000 -> LE_O=0, Mant=0xC0000000. IN=0xC0000000 -> Sign=1, LE_O=0, Mant=0x80000000.
- Extremes: IN=0x00000001 -> R_O=30, LE_O=-120, E_O=0, Mant=0x80000000. IN=0x7FFFFFFF -> R_O=31, LE_O=120, E_O=0, Mant=0x80000000.
- Specials: IN=0x00000000 -> zero=1, inf=0, others 0. IN=0x80000000 -> inf=1, Sign=1, others 0.
- Backpressure: stream 8 random words with in_valid=1 and out_ready toggling 1/0/0/1.
  - Outputs must appear in order, unduplicated, and match a software reference.
  - in_ready=0 only while both stages are full and out_ready=0.
- Reset mid-stream: assert rst_n=0 with both stages valid -> out_valid=0 and all outputs 0 asynchronously.
  - After release, no stale word ever appears on the output.
